ps2_mouse_device_sm: RTL and testbench

- Device-side (mouse) state machine for the PS/2 byte protocol; the responder to the host master that issues FF/F4 and reads 3-byte movement packets.
- Sits between a byte-level PS/2 device transmitter/receiver pair and a movement source (test pattern, trackball or sensor logic).
- Answers host commands (reset, enable, disable), runs the power-on/reset BAT sequence, accumulates movement and streams 3-byte packets while reporting is enabled.
- Used as a mouse model for host bring-up and as an on-board emulator.

---
 rtl/ps2_mouse_device_sm.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_device_sm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_device_sm.sv
// PS/2 mouse device-side state machine: command responses, BAT sequence and 3-byte movement packets.
// Define MOUSE_DEV_ECHO_EN to make command EE echo EE instead of being rejected with FE.
module ps2_mouse_device_sm #(
  parameter int         RESP_DELAY = 2000,
  parameter int         BAT_DELAY  = 500000,
  parameter logic [7:0] ACK_BYTE   = 8'hFA
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_IN_VALID,
  input  logic [1:0] BYTE_IN_ERROR,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       MOVE_VALID,
  input  logic [8:0] MOVE_DX,
  input  logic [8:0] MOVE_DY,
  input  logic [2:0] BUTTONS,
  output logic       REPORTING,
  output logic [3:0] CURR_STATE
);

  localparam int CNT_MAX = (BAT_DELAY > RESP_DELAY) ? BAT_DELAY : RESP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE      = 4'h0,
    RESP_WAIT = 4'h1,
    SEND_RESP = 4'h2,
    WAIT_RESP = 4'h3,
    BAT_WAIT  = 4'h4,
    SEND_AA   = 4'h5,
    WAIT_AA   = 4'h6,
    SEND_ID   = 4'h7,
    WAIT_ID   = 4'h8,
    STREAM    = 4'h9,
    SEND_B0   = 4'hA,
    SEND_B1   = 4'hB,
    SEND_B2   = 4'hC
  } state_t;

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_ENABLE,
    ACT_DISABLE,
    ACT_RESTORE
  } act_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             send_reg, send_next;
  logic [7:0]       tx_byte_reg, tx_byte_next;
  logic             reporting_reg, reporting_next;
  logic             pend_reg;
  logic [7:0]       pend_byte_reg;
  logic [1:0]       pend_err_reg;
  logic [7:0]       resp_byte_reg, resp_byte_next;
  act_t             act_reg, act_next;
  logic [7:0]       pkt_b1_reg, pkt_b1_next;
  logic [7:0]       pkt_b2_reg, pkt_b2_next;
  logic [2:0]       last_btn_reg, last_btn_next;
  logic             moved_reg, moved_next;

  logic             go_resp, pend_clr, snap, acc_clr;
  logic [7:0]       dec_byte;
  act_t             dec_act;
  logic [7:0]       b0_byte;

  // Per-axis saturating accumulators (0 = X, 1 = Y)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [9:0]  acc_reg, acc_next;
      logic               ovf_reg, ovf_next;
      logic signed [10:0] sum;
      logic [8:0]         delta;

      assign delta = (gi == 0) ? MOVE_DX : MOVE_DY;

      always_comb begin
        sum      = '0;
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (!reporting_reg) begin
          acc_next = '0;
          ovf_next = 1'b0;
        end else begin
          if (snap || acc_clr) begin
            acc_next = '0;
            ovf_next = 1'b0;
          end
          if (MOVE_VALID) begin
            sum = {acc_next[9], acc_next} + {{2{delta[8]}}, delta};
            if (sum > 11'sd255) begin
              acc_next = 10'sd255;
              ovf_next = 1'b1;
            end else if (sum < -11'sd256) begin
              acc_next = -10'sd256;
              ovf_next = 1'b1;
            end else begin
              acc_next = sum[9:0];
            end
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else begin
          acc_reg <= acc_next;
          ovf_reg <= ovf_next;
        end
      end
    end
  endgenerate

  assign b0_byte = {g_axis[1].ovf_reg, g_axis[0].ovf_reg, g_axis[1].acc_reg[8],
                    g_axis[0].acc_reg[8], 1'b1, BUTTONS};

  always_comb begin
    dec_byte = 8'hFE;
    dec_act  = ACT_RESTORE;
    if (pend_err_reg == 2'b00) begin
      case (pend_byte_reg)
        8'hFF: begin dec_byte = ACK_BYTE; dec_act = ACT_RESET;   end
        8'hF4: begin dec_byte = ACK_BYTE; dec_act = ACT_ENABLE;  end
        8'hF5: begin dec_byte = ACK_BYTE; dec_act = ACT_DISABLE; end
`ifdef MOUSE_DEV_ECHO_EN
        8'hEE: begin dec_byte = 8'hEE;    dec_act = ACT_RESTORE; end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    send_next      = 1'b0;
    tx_byte_next   = tx_byte_reg;
    reporting_next = reporting_reg;
    resp_byte_next = resp_byte_reg;
    act_next       = act_reg;
    pkt_b1_next    = pkt_b1_reg;
    pkt_b2_next    = pkt_b2_reg;
    last_btn_next  = last_btn_reg;
    go_resp        = 1'b0;
    pend_clr       = 1'b0;
    snap           = 1'b0;
    acc_clr        = 1'b0;

    case (state_reg)
      IDLE: if (pend_reg) go_resp = 1'b1;
      RESP_WAIT: begin
        if (cnt_reg == CNT_W'(RESP_DELAY - 1)) begin
          state_next   = SEND_RESP;
          send_next    = 1'b1;
          tx_byte_next = resp_byte_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      SEND_RESP: state_next = WAIT_RESP;
      WAIT_RESP: begin
        if (BYTE_SENT) begin
          if (pend_reg) go_resp = 1'b1;
          else begin
            case (act_reg)
              ACT_RESET: begin
                state_next     = BAT_WAIT;
                cnt_next       = '0;
                reporting_next = 1'b0;
              end
              ACT_ENABLE: begin
                state_next     = STREAM;
                reporting_next = 1'b1;
                acc_clr        = 1'b1;
              end
              ACT_DISABLE: begin
                state_next     = IDLE;
                reporting_next = 1'b0;
                acc_clr        = 1'b1;
              end
              default: state_next = reporting_reg ? STREAM : IDLE;
            endcase
          end
        end
      end
      BAT_WAIT: begin
        if (pend_reg) go_resp = 1'b1;
        else if (cnt_reg == CNT_W'(BAT_DELAY - 1)) begin
          state_next   = SEND_AA;
          send_next    = 1'b1;
          tx_byte_next = 8'hAA;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      SEND_AA: state_next = WAIT_AA;
      WAIT_AA: begin
        if (BYTE_SENT) begin
          if (pend_reg) go_resp = 1'b1;
          else begin
            state_next   = SEND_ID;
            send_next    = 1'b1;
            tx_byte_next = 8'h00;
          end
        end
      end
      SEND_ID: state_next = WAIT_ID;
      WAIT_ID: begin
        if (BYTE_SENT) begin
          if (pend_reg) go_resp = 1'b1;
          else state_next = IDLE;
        end
      end
      STREAM: begin
        if (pend_reg) go_resp = 1'b1;
        else if (moved_reg || (BUTTONS != last_btn_reg)) begin
          snap          = 1'b1;
          state_next    = SEND_B0;
          send_next     = 1'b1;
          tx_byte_next  = b0_byte;
          pkt_b1_next   = g_axis[0].acc_reg[7:0];
          pkt_b2_next   = g_axis[1].acc_reg[7:0];
          last_btn_next = BUTTONS;
        end
      end
      // A strobe coinciding with our own request cannot belong to this byte
      SEND_B0, SEND_B1: begin
        if (BYTE_SENT && !send_reg) begin
          if (pend_reg) go_resp = 1'b1;
          else begin
            state_next   = (state_reg == SEND_B0) ? SEND_B1 : SEND_B2;
            send_next    = 1'b1;
            tx_byte_next = (state_reg == SEND_B0) ? pkt_b1_reg : pkt_b2_reg;
          end
        end
      end
      SEND_B2: begin
        if (BYTE_SENT && !send_reg) begin
          if (pend_reg) go_resp = 1'b1;
          else state_next = STREAM;
        end
      end
      default: begin
        state_next = BAT_WAIT;
        cnt_next   = '0;
      end
    endcase

    if (go_resp) begin
      state_next     = RESP_WAIT;
      cnt_next       = '0;
      pend_clr       = 1'b1;
      resp_byte_next = dec_byte;
      act_next       = dec_act;
    end
  end

  always_comb begin
    moved_next = moved_reg;
    if (!reporting_reg) moved_next = 1'b0;
    else if (MOVE_VALID) moved_next = 1'b1;
    else if (snap || acc_clr) moved_next = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= BAT_WAIT;
      cnt_reg       <= '0;
      send_reg      <= 1'b0;
      tx_byte_reg   <= 8'h00;
      reporting_reg <= 1'b0;
      pend_reg      <= 1'b0;
      pend_byte_reg <= 8'h00;
      pend_err_reg  <= 2'b00;
      resp_byte_reg <= 8'h00;
      act_reg       <= ACT_RESTORE;
      pkt_b1_reg    <= 8'h00;
      pkt_b2_reg    <= 8'h00;
      last_btn_reg  <= 3'b000;
      moved_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      send_reg      <= send_next;
      tx_byte_reg   <= tx_byte_next;
      reporting_reg <= reporting_next;
      resp_byte_reg <= resp_byte_next;
      act_reg       <= act_next;
      pkt_b1_reg    <= pkt_b1_next;
      pkt_b2_reg    <= pkt_b2_next;
      last_btn_reg  <= last_btn_next;
      moved_reg     <= moved_next;
      // A new host byte always wins over clearing the one being serviced
      if (BYTE_IN_VALID) begin
        pend_reg      <= 1'b1;
        pend_byte_reg <= BYTE_IN;
        pend_err_reg  <= BYTE_IN_ERROR;
      end else if (pend_clr) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign SEND_BYTE    = send_reg;
  assign BYTE_TO_SEND = tx_byte_reg;
  assign REPORTING    = reporting_reg;
  assign CURR_STATE   = state_reg;

endmodule

// File: tb/tb_ps2_mouse_device_sm.sv
// Directed bench for ps2_mouse_device_sm: BAT sequence, commands, packets, overflow, abort and reset.
module tb_ps2_mouse_device_sm;

  localparam int RESP = 10;
  localparam int BAT  = 20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] BYTE_IN;
  logic       BYTE_IN_VALID;
  logic [1:0] BYTE_IN_ERROR;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       MOVE_VALID;
  logic [8:0] MOVE_DX;
  logic [8:0] MOVE_DY;
  logic [2:0] BUTTONS;
  logic       REPORTING;
  logic [3:0] CURR_STATE;

  int checks   = 0;
  int failures = 0;

  ps2_mouse_device_sm #(
    .RESP_DELAY(RESP),
    .BAT_DELAY (BAT),
    .ACK_BYTE  (8'hFA)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BYTE_IN      (BYTE_IN),
    .BYTE_IN_VALID(BYTE_IN_VALID),
    .BYTE_IN_ERROR(BYTE_IN_ERROR),
    .SEND_BYTE    (SEND_BYTE),
    .BYTE_TO_SEND (BYTE_TO_SEND),
    .BYTE_SENT    (BYTE_SENT),
    .MOVE_VALID   (MOVE_VALID),
    .MOVE_DX      (MOVE_DX),
    .MOVE_DY      (MOVE_DY),
    .BUTTONS      (BUTTONS),
    .REPORTING    (REPORTING),
    .CURR_STATE   (CURR_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for a SEND_BYTE pulse and checks the byte that comes with it
  task automatic wait_send(input string tag, input logic [7:0] exp, output int lat,
                           output logic [7:0] got_byte);
    lat = 0;
    while (!SEND_BYTE && lat < 80) begin
      tick();
      lat++;
    end
    got_byte = BYTE_TO_SEND;
    $display("tx %s: send=%0b byte=%02h expected=%02h latency=%0d", tag, SEND_BYTE, BYTE_TO_SEND, exp, lat);
    check({tag, "_seen"}, 32'(SEND_BYTE), 32'd1);
    check({tag, "_byte"}, 32'(BYTE_TO_SEND), 32'(exp));
  endtask

  // Checks the request is a single pulse and the byte is held, then reports the byte done
  task automatic finish_byte(input string tag, input logic [7:0] exp);
    tick();
    check({tag, "_pulse"}, 32'(SEND_BYTE), 32'd0);
    tick();
    check({tag, "_held"}, 32'(BYTE_TO_SEND), 32'(exp));
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  task automatic host(input logic [7:0] b, input logic [1:0] err);
    BYTE_IN       = b;
    BYTE_IN_ERROR = err;
    BYTE_IN_VALID = 1'b1;
    tick();
    BYTE_IN_VALID = 1'b0;
    BYTE_IN_ERROR = 2'b00;
  endtask

  task automatic move(input logic [8:0] dx, input logic [8:0] dy);
    MOVE_DX    = dx;
    MOVE_DY    = dy;
    MOVE_VALID = 1'b1;
    tick();
    MOVE_VALID = 1'b0;
  endtask

  initial begin
    int         lat;
    int         stray;
    logic [7:0] b;
    logic [7:0] echo_exp;

`ifdef MOUSE_DEV_ECHO_EN
    echo_exp = 8'hEE;
`else
    echo_exp = 8'hFE;
`endif

    RESET = 1'b1; BYTE_IN = 8'h00; BYTE_IN_VALID = 1'b0; BYTE_IN_ERROR = 2'b00;
    BYTE_SENT = 1'b0; MOVE_VALID = 1'b0; MOVE_DX = '0; MOVE_DY = '0; BUTTONS = 3'b000;
    repeat (3) tick();
    check("rst_send", 32'(SEND_BYTE), 32'd0);
    check("rst_byte", 32'(BYTE_TO_SEND), 32'h00);
    check("rst_rep", 32'(REPORTING), 32'd0);
    check("rst_state", 32'(CURR_STATE), 32'd4);

    // Power-on BAT sequence
    RESET = 1'b0;
    wait_send("bat_aa", 8'hAA, lat, b);
    check("bat_latency", 32'(lat), 32'(BAT));
    finish_byte("bat_aa", 8'hAA);
    wait_send("bat_id", 8'h00, lat, b);
    finish_byte("bat_id", 8'h00);
    check("bat_idle_state", 32'(CURR_STATE), 32'd0);
    check("bat_idle_rep", 32'(REPORTING), 32'd0);

    // FF: ACK, BAT, AA, ID
    host(8'hFF, 2'b00);
    wait_send("ff_ack", 8'hFA, lat, b);
    check("resp_latency_ok", 32'(lat >= RESP && lat <= RESP + 3), 32'd1);
    finish_byte("ff_ack", 8'hFA);
    check("ff_bat_state", 32'(CURR_STATE), 32'd4);
    wait_send("ff_aa", 8'hAA, lat, b);
    check("ff_bat_latency", 32'(lat), 32'(BAT));
    finish_byte("ff_aa", 8'hAA);
    wait_send("ff_id", 8'h00, lat, b);
    finish_byte("ff_id", 8'h00);
    check("ff_idle_state", 32'(CURR_STATE), 32'd0);

    // F4: enable streaming
    host(8'hF4, 2'b00);
    wait_send("f4_ack", 8'hFA, lat, b);
    finish_byte("f4_ack", 8'hFA);
    check("f4_rep", 32'(REPORTING), 32'd1);
    check("f4_state", 32'(CURR_STATE), 32'd9);

    // Packet 1: +5, -3, left button
    move(9'd5, 9'h1FD);
    BUTTONS = 3'b001;
    wait_send("p1_b0", 8'h29, lat, b);
    // Three +200 moves while packet 1 is in flight saturate X
    move(9'd200, 9'd0);
    move(9'd200, 9'd0);
    move(9'd200, 9'd0);
    finish_byte("p1_b0", 8'h29);
    wait_send("p1_b1", 8'h05, lat, b);
    finish_byte("p1_b1", 8'h05);
    wait_send("p1_b2", 8'hFD, lat, b);
    finish_byte("p1_b2", 8'hFD);

    // Packet 2: X overflow
    wait_send("p2_b0", 8'h49, lat, b);
    check("p2_ovf_x_bit6", 32'(b[6]), 32'd1);
    check("p2_sign_x_bit4", 32'(b[4]), 32'd0);
    finish_byte("p2_b0", 8'h49);
    wait_send("p2_b1", 8'hFF, lat, b);
    finish_byte("p2_b1", 8'hFF);
    wait_send("p2_b2", 8'h00, lat, b);
    finish_byte("p2_b2", 8'h00);

    // Packet 3 interrupted by F5 during B1: B2 is dropped
    move(9'd1, 9'd1);
    wait_send("p3_b0", 8'h09, lat, b);
    finish_byte("p3_b0", 8'h09);
    wait_send("p3_b1", 8'h01, lat, b);
    host(8'hF5, 2'b00);
    finish_byte("p3_b1", 8'h01);
    wait_send("f5_ack", 8'hFA, lat, b);
    finish_byte("f5_ack", 8'hFA);
    check("f5_rep", 32'(REPORTING), 32'd0);
    check("f5_state", 32'(CURR_STATE), 32'd0);

    // Movement while disabled produces nothing
    move(9'd7, 9'd7);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (SEND_BYTE) stray++;
    end
    check("disabled_no_packet", 32'(stray), 32'd0);

    // Error byte in IDLE: FE, stay idle
    host(8'h12, 2'b01);
    wait_send("err_idle", 8'hFE, lat, b);
    finish_byte("err_idle", 8'hFE);
    check("err_idle_state", 32'(CURR_STATE), 32'd0);
    check("err_idle_rep", 32'(REPORTING), 32'd0);

    // EE: echoed only when the echo option is built in
    host(8'hEE, 2'b00);
    wait_send("echo", echo_exp, lat, b);
    finish_byte("echo", echo_exp);
    check("echo_state", 32'(CURR_STATE), 32'd0);

    // Error byte while streaming: FE, streaming continues
    host(8'hF4, 2'b00);
    wait_send("f4b_ack", 8'hFA, lat, b);
    finish_byte("f4b_ack", 8'hFA);
    host(8'h12, 2'b01);
    wait_send("err_stream", 8'hFE, lat, b);
    finish_byte("err_stream", 8'hFE);
    check("err_stream_state", 32'(CURR_STATE), 32'd9);
    check("err_stream_rep", 32'(REPORTING), 32'd1);

    // Reset while a response is in flight
    host(8'hF5, 2'b00);
    wait_send("pre_rst", 8'hFA, lat, b);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midrst_send", 32'(SEND_BYTE), 32'd0);
    check("midrst_byte", 32'(BYTE_TO_SEND), 32'h00);
    check("midrst_rep", 32'(REPORTING), 32'd0);
    check("midrst_state", 32'(CURR_STATE), 32'd4);
    wait_send("rst_aa", 8'hAA, lat, b);
    check("rst_bat_latency", 32'(lat), 32'(BAT));
    finish_byte("rst_aa", 8'hAA);
    wait_send("rst_id", 8'h00, lat, b);
    finish_byte("rst_id", 8'h00);
    check("rst_final_state", 32'(CURR_STATE), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
